ssram_arbiter: RTL and testbench

SSRAM_ARBITER -- requirements
Module: ssram_arbiter

---
 rtl/ssram_arb_pkg.sv | 19 +
 rtl/ssram_rr_arb.sv | 23 ++
 rtl/ssram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_ssram_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssram_arb_pkg.sv
// Shared types for the two-port SSRAM arbiter: FSM state encoding and port identifiers.
package ssram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RD   = 2'd2
    } state_e;

    typedef logic port_id_t;

    localparam port_id_t PORT_A = 1'b0;
    localparam port_id_t PORT_B = 1'b1;

    function automatic port_id_t other_port(input port_id_t p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/ssram_rr_arb.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port not granted last.
module ssram_rr_arb
    import ssram_arb_pkg::*;
(
    input  logic     req_a_i,
    input  logic     req_b_i,
    input  port_id_t last_i,
    output port_id_t winner_o,
    output logic     valid_o
);

    // NOTE: every output gets a default first, so no path through this block can infer a latch.
    always_comb begin
        winner_o = PORT_A;
        valid_o  = req_a_i | req_b_i;
        if (req_a_i && req_b_i) begin
            winner_o = other_port(last_i);
        end else if (req_b_i) begin
            winner_o = PORT_B;
        end
    end

endmodule

// File: rtl/ssram_arbiter.sv
// Shares one single-ported SSRAM between a 6502 bus port (A) and a QOI engine port (B),
// one access in flight at a time: IDLE -> ACC (write done) or IDLE -> ACC -> RD (read).
module ssram_arbiter
    import ssram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);

    state_e                state_q;
    port_id_t              owner_q;
    port_id_t              last_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  cs_q;
    logic                  mwe_q;
    logic                  oe_q;
    logic                  drive_q;
    logic                  a_gnt_q;
    logic                  b_gnt_q;
    logic                  a_rvalid_q;
    logic                  b_rvalid_q;
    logic [DATA_WIDTH-1:0] a_rdata_q;
    logic [DATA_WIDTH-1:0] b_rdata_q;

    port_id_t              winner;
    logic                  arb_valid;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    ssram_rr_arb u_rr_arb (
        .req_a_i  (a_req),
        .req_b_i  (b_req),
        .last_i   (last_q),
        .winner_o (winner),
        .valid_o  (arb_valid)
    );

    always_comb begin
        win_we    = a_we;
        win_addr  = a_addr;
        win_wdata = a_wdata;
        if (winner == PORT_B) begin
            win_we    = b_we;
            win_addr  = b_addr;
            win_wdata = b_wdata;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= PORT_A;
            last_q     <= PORT_B;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            cs_q       <= 1'b0;
            mwe_q      <= 1'b0;
            oe_q       <= 1'b0;
            drive_q    <= 1'b0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        state_q <= ACC;
                        owner_q <= winner;
                        last_q  <= winner;
                        addr_q  <= win_addr;
                        we_q    <= win_we;
                        wdata_q <= win_wdata;
                        cs_q    <= 1'b1;
                        mwe_q   <= win_we;
                        oe_q    <= 1'b0;
                        drive_q <= win_we;
                        a_gnt_q <= (winner == PORT_A);
                        b_gnt_q <= (winner == PORT_B);
                    end
                end
                ACC: begin
                    mwe_q   <= 1'b0;
                    drive_q <= 1'b0;
                    if (we_q) begin
                        state_q <= IDLE;
                        cs_q    <= 1'b0;
                    end else begin
                        state_q <= RD;
                        oe_q    <= 1'b1;
                    end
                end
                RD: begin
                    // The RAM has had the whole RD cycle to drive the bus; sample it on leaving.
                    state_q <= IDLE;
                    cs_q    <= 1'b0;
                    oe_q    <= 1'b0;
                    if (owner_q == PORT_A) begin
                        a_rdata_q  <= mem_data;
                        a_rvalid_q <= 1'b1;
                    end else begin
                        b_rdata_q  <= mem_data;
                        b_rvalid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cs_q    <= 1'b0;
                    mwe_q   <= 1'b0;
                    oe_q    <= 1'b0;
                    drive_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_data = drive_q ? wdata_q : 'z;
    assign mem_addr = addr_q;
    assign mem_cs   = cs_q;
    assign mem_we   = mwe_q;
    assign mem_oe   = oe_q;
    assign a_gnt    = a_gnt_q;
    assign b_gnt    = b_gnt_q;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

`ifndef SYNTHESIS
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(a_gnt_q && b_gnt_q));
    bus_drive_acc: assert property (@(posedge clk) disable iff (!rst_n)
        drive_q |-> (state_q == ACC && we_q));
    no_we_oe: assert property (@(posedge clk) disable iff (!rst_n) !(mwe_q && oe_q));
`endif

endmodule

// File: tb/tb_ssram_arbiter.sv
// Self-checking bench: bench-side SSRAM plus a transaction-level reference model of arbitration,
// timing and memory contents, driven by per-port request queues.
module tb_ssram_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1024;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;
    logic          mem_cs, mem_we, mem_oe;

    ssram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
    );

    always #5 clk = ~clk;

    // Bench SSRAM: synchronous write, asynchronous read while output-enabled.
    logic [DW-1:0] ram [DEPTH] = '{default: '0};
    always @(posedge clk) if (mem_cs && mem_we) ram[mem_addr] <= mem_data;
    assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram[mem_addr] : 'z;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            gap;
        int            drop_after;
    } req_t;
    typedef struct { int cyc; bit port; } gnt_ev_t;
    typedef struct { int cyc; logic [DW-1:0] data; } rd_ev_t;

    req_t          q_a[$], q_b[$];
    gnt_ev_t       gnt_log[$];
    rd_ev_t        rd_log_a[$], rd_log_b[$];
    logic [AW-1:0] acc_log[$];

    bit   act [2];
    bit   have [2];
    req_t cur [2];
    int   wait_c [2];
    int   held [2];

    logic [DW-1:0] mm [DEPTH] = '{default: '0};
    bit            m_last;
    int            m_busy;
    bit            acc_v;
    int            acc_cyc;
    bit            acc_we;
    bit            acc_port;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_data;
    int            rd_due [2];
    logic [DW-1:0] rd_val [2];
    logic [DW-1:0] rdata_m [2];
    int            m_reads [2];

    function automatic req_t mk(bit we, logic [AW-1:0] addr, logic [DW-1:0] data, int gap, int drop);
        req_t r;
        r.we = we; r.addr = addr; r.data = data; r.gap = gap; r.drop_after = drop;
        return r;
    endfunction

    task automatic drive_pins();
        a_req = act[0]; a_we = cur[0].we; a_addr = cur[0].addr; a_wdata = cur[0].data;
        b_req = act[1]; b_we = cur[1].we; b_addr = cur[1].addr; b_wdata = cur[1].data;
    endtask

    // Requester behaviour: hold until granted, optionally give up early, then fetch the next item.
    task automatic drv_step(input bit g0, input bit g1);
        bit g [2];
        g[0] = g0; g[1] = g1;
        for (int p = 0; p < 2; p++) begin
            if (act[p] && g[p]) begin
                act[p] = 0; have[p] = 0;
            end else if (act[p]) begin
                held[p]++;
                if (cur[p].drop_after >= 0 && held[p] >= cur[p].drop_after) begin
                    act[p] = 0; have[p] = 0;
                end
            end
            if (!have[p]) begin
                if (p == 0 && q_a.size() > 0) begin
                    cur[p] = q_a.pop_front(); have[p] = 1; wait_c[p] = cur[p].gap; held[p] = 0;
                end else if (p == 1 && q_b.size() > 0) begin
                    cur[p] = q_b.pop_front(); have[p] = 1; wait_c[p] = cur[p].gap; held[p] = 0;
                end
            end
            if (have[p] && !act[p]) begin
                if (wait_c[p] == 0) act[p] = 1;
                else wait_c[p]--;
            end
        end
        drive_pins();
    endtask

    // Resets the DUT, then plays both queues while comparing every cycle against the model.
    task automatic run_engine(input string name, input int max_cyc);
        int  j;
        bit  done, pa, pb, win, eg0, eg1, in_acc, in_rd, exp_rv, rv;
        logic [DW-1:0] rd;
        m_last = 1'b1; m_busy = 0; acc_v = 0; acc_cyc = -10; acc_we = 0; acc_port = 0;
        acc_addr = '0; acc_data = '0;
        for (int p = 0; p < 2; p++) begin
            rd_due[p] = -1; rd_val[p] = '0; rdata_m[p] = '0; m_reads[p] = 0;
            act[p] = 0; have[p] = 0; held[p] = 0; wait_c[p] = 0;
        end
        gnt_log.delete(); rd_log_a.delete(); rd_log_b.delete(); acc_log.delete();
        @(negedge clk);
        rst_n = 1'b0;
        drv_step(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        j = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            pa = a_req; pb = b_req; eg0 = 0; eg1 = 0;
            if (j >= m_busy && (pa || pb)) begin
                win = (pa && pb) ? !m_last : (pa ? 1'b0 : 1'b1);
                if (win) eg1 = 1; else eg0 = 1;
                acc_v = 1; acc_cyc = j; acc_we = cur[win].we; acc_port = win;
                acc_addr = cur[win].addr; acc_data = cur[win].data;
                m_busy = j + (acc_we ? 2 : 3);
                m_last = win;
                if (acc_we) mm[acc_addr] = acc_data;
                else begin
                    rd_due[win] = j + 2; rd_val[win] = mm[acc_addr]; m_reads[win]++;
                end
            end
            checks++;
            if ({a_gnt, b_gnt} !== {eg0, eg1}) begin
                errors++;
                $display("FAIL %s gnt cyc=%0d got a/b=%b%b exp=%b%b", name, j, a_gnt, b_gnt, eg0, eg1);
            end
            if (a_gnt === 1'b1) gnt_log.push_back('{j, 1'b0});
            if (b_gnt === 1'b1) gnt_log.push_back('{j, 1'b1});
            in_acc = acc_v && (j == acc_cyc);
            in_rd  = acc_v && !acc_we && (j == acc_cyc + 1);
            checks++;
            if ({mem_cs, mem_we, mem_oe} !== {in_acc || in_rd, in_acc && acc_we, in_rd}) begin
                errors++;
                $display("FAIL %s ctl cyc=%0d got cs/we/oe=%b%b%b exp=%b%b%b", name, j,
                         mem_cs, mem_we, mem_oe, in_acc || in_rd, in_acc && acc_we, in_rd);
            end
            if (mem_cs === 1'b1 && mem_oe === 1'b0) acc_log.push_back(mem_addr);
            if (in_acc || in_rd) begin
                checks++;
                if (mem_addr !== acc_addr) begin
                    errors++;
                    $display("FAIL %s addr cyc=%0d got=%h exp=%h", name, j, mem_addr, acc_addr);
                end
            end
            if (in_acc && acc_we) begin
                checks++;
                if (mem_data !== acc_data) begin
                    errors++;
                    $display("FAIL %s wbus cyc=%0d got=%h exp=%h", name, j, mem_data, acc_data);
                end
            end
            if (in_rd) begin
                checks++;
                if (mem_data !== rd_val[acc_port]) begin
                    errors++;
                    $display("FAIL %s rbus cyc=%0d got=%h exp=%h", name, j, mem_data, rd_val[acc_port]);
                end
            end
            for (int p = 0; p < 2; p++) begin
                exp_rv = (j == rd_due[p]);
                if (exp_rv) rdata_m[p] = rd_val[p];
                rv = (p == 0) ? a_rvalid : b_rvalid;
                rd = (p == 0) ? a_rdata : b_rdata;
                checks++;
                if ({rv, rd} !== {exp_rv, rdata_m[p]}) begin
                    errors++;
                    $display("FAIL %s rd%0d cyc=%0d got v=%b d=%h exp v=%b d=%h", name, p, j,
                             rv, rd, exp_rv, rdata_m[p]);
                end
                if (rv === 1'b1) begin
                    if (p == 0) rd_log_a.push_back('{j, rd});
                    else rd_log_b.push_back('{j, rd});
                end
            end
            drv_step(eg0, eg1);
            if (!have[0] && !have[1] && j >= m_busy) done = 1;
            else if (j >= max_cyc) begin
                checks++; errors++;
                $display("FAIL %s timeout after %0d cycles", name, j);
                done = 1;
            end
            j++;
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b1;
        #1;
        checks++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid, mem_cs, mem_we, mem_oe} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl got=%b exp=0", {a_gnt, b_gnt, a_rvalid, b_rvalid, mem_cs, mem_we, mem_oe});
        end
        checks++;
        if ({a_rdata, b_rdata, mem_addr} !== '0) begin
            errors++;
            $display("FAIL reset_data got a=%h b=%h addr=%h exp 0", a_rdata, b_rdata, mem_addr);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_gnt, b_gnt, mem_cs} !== 3'b0) begin
            errors++;
            $display("FAIL reset_hold got gnt=%b%b cs=%b exp 000", a_gnt, b_gnt, mem_cs);
        end
        a_req = 1'b0; b_req = 1'b0;
    endtask

    task automatic test_a_write_read();
        q_a.push_back(mk(1, 10'h010, 8'h5A, 0, -1));
        q_a.push_back(mk(0, 10'h010, 8'h00, 0, -1));
        run_engine("a_wr_rd", 50);
        checks++;
        if (gnt_log.size() != 2 || gnt_log[0].port != 0 || gnt_log[1].port != 0
            || gnt_log[0].cyc != 0 || gnt_log[1].cyc != 2) begin
            errors++;
            $display("FAIL a_wr_rd grants got n=%0d exp 2 A grants at cyc 0,2", gnt_log.size());
        end
        checks++;
        if (rd_log_a.size() != 1 || rd_log_a[0].data !== 8'h5A || rd_log_a[0].cyc != 4
            || rd_log_b.size() != 0) begin
            errors++;
            $display("FAIL a_wr_rd rdata got nA=%0d nB=%0d exp one A read 5a at cyc 4",
                     rd_log_a.size(), rd_log_b.size());
        end
    endtask

    task automatic test_tie_from_reset();
        q_a.push_back(mk(1, 10'h001, 8'h11, 0, -1));
        q_a.push_back(mk(1, 10'h002, 8'h22, 0, -1));
        run_engine("tie_preload", 50);
        q_a.push_back(mk(0, 10'h001, 8'h00, 0, -1));
        q_b.push_back(mk(0, 10'h002, 8'h00, 0, -1));
        run_engine("tie", 50);
        checks++;
        if (gnt_log.size() != 2 || gnt_log[0].port != 0 || gnt_log[0].cyc != 0
            || gnt_log[1].port != 1 || gnt_log[1].cyc != 3) begin
            errors++;
            $display("FAIL tie order got n=%0d exp A@0 then B@3", gnt_log.size());
        end
        checks++;
        if (rd_log_a.size() != 1 || rd_log_b.size() != 1
            || rd_log_a[0].data !== 8'h11 || rd_log_b[0].data !== 8'h22) begin
            errors++;
            $display("FAIL tie rdata got nA=%0d nB=%0d exp a=11 b=22", rd_log_a.size(), rd_log_b.size());
        end
    endtask

    task automatic test_alternation();
        for (int i = 0; i < 4; i++) begin
            q_a.push_back(mk(1'($urandom_range(0, 1)), AW'(10'h100 + i), DW'($urandom), 0, -1));
            q_b.push_back(mk(1'($urandom_range(0, 1)), AW'(10'h180 + i), DW'($urandom), 0, -1));
        end
        run_engine("alternate", 100);
        checks++;
        if (gnt_log.size() != 8) begin
            errors++;
            $display("FAIL alternate count got=%0d exp=8", gnt_log.size());
        end
        for (int i = 0; i < gnt_log.size(); i++) begin
            checks++;
            if (gnt_log[i].port != 1'(i % 2)) begin
                errors++;
                $display("FAIL alternate order idx=%0d got=%0d exp=%0d", i, gnt_log[i].port, i % 2);
            end
        end
    endtask

    task automatic test_b_top_addr();
        q_b.push_back(mk(1, 10'h3FF, 8'hC3, 0, -1));
        q_b.push_back(mk(0, 10'h3FF, 8'h00, 0, -1));
        run_engine("b_top", 50);
        checks++;
        if (rd_log_b.size() != 1 || rd_log_b[0].data !== 8'hC3 || rd_log_a.size() != 0) begin
            errors++;
            $display("FAIL b_top rdata got nB=%0d exp one B read c3", rd_log_b.size());
        end
        checks++;
        if (acc_log.size() != 2 || acc_log[0] !== 10'h3FF || acc_log[1] !== 10'h3FF) begin
            errors++;
            $display("FAIL b_top accesses got n=%0d exp two at 3ff", acc_log.size());
        end
    endtask

    task automatic test_reset_mid_write();
        q_a.push_back(mk(1, 10'h020, 8'h00, 0, -1));
        q_a.push_back(mk(0, 10'h010, 8'h00, 0, -1));
        run_engine("rst_preload", 50);
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 10'h020; a_wdata = 8'hFF;
        @(posedge clk);
        #1;
        checks++;
        if ({a_gnt, mem_cs, mem_we} !== 3'b111) begin
            errors++;
            $display("FAIL rst_mid acc got gnt/cs/we=%b%b%b exp 111", a_gnt, mem_cs, mem_we);
        end
        #2 rst_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0;
        #1;
        checks++;
        if ({a_gnt, a_rvalid, mem_cs, mem_we, mem_oe} !== 5'b0 || a_rdata !== 8'h00 || mem_addr !== '0) begin
            errors++;
            $display("FAIL rst_mid outputs got ctl=%b rdata=%h addr=%h exp all 0",
                     {a_gnt, a_rvalid, mem_cs, mem_we, mem_oe}, a_rdata, mem_addr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ram[10'h020] !== 8'h00 || a_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid ram got=%h rvalid=%b exp 00 0", ram[10'h020], a_rvalid);
        end
        q_a.push_back(mk(0, 10'h020, 8'h00, 0, -1));
        run_engine("rst_readback", 50);
        checks++;
        if (rd_log_a.size() != 1 || rd_log_a[0].data !== 8'h00) begin
            errors++;
            $display("FAIL rst_readback got n=%0d exp one read of 00", rd_log_a.size());
        end
    endtask

    task automatic test_drop_before_grant();
        q_b.push_back(mk(0, 10'h005, 8'h00, 0, -1));
        q_a.push_back(mk(1, 10'h030, 8'h77, 1, 1));
        run_engine("drop", 50);
        checks++;
        if (gnt_log.size() != 1 || gnt_log[0].port != 1) begin
            errors++;
            $display("FAIL drop grants got n=%0d exp only one B grant", gnt_log.size());
        end
        foreach (acc_log[i]) begin
            checks++;
            if (acc_log[i] === 10'h030) begin
                errors++;
                $display("FAIL drop access got addr=%h exp never 030", acc_log[i]);
            end
        end
        checks++;
        if (ram[10'h030] === 8'h77) begin
            errors++;
            $display("FAIL drop ram got=%h exp unwritten", ram[10'h030]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            for (int p = 0; p < 2; p++) begin
                req_t r;
                r = mk(1'($urandom_range(0, 1)),
                       ($urandom_range(0, 7) == 0) ? 10'h3FF : AW'($urandom_range(0, 15)),
                       DW'($urandom), $urandom_range(0, 2),
                       ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : -1);
                if (p == 0) q_a.push_back(r); else q_b.push_back(r);
            end
        end
        run_engine("random", 3000);
        checks++;
        if (rd_log_a.size() != m_reads[0] || rd_log_b.size() != m_reads[1]) begin
            errors++;
            $display("FAIL random read count got a=%0d b=%0d exp a=%0d b=%0d",
                     rd_log_a.size(), rd_log_b.size(), m_reads[0], m_reads[1]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_a_write_read();
        test_tie_from_reset();
        test_alternation();
        test_b_top_addr();
        test_reset_mid_write();
        test_drop_before_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
